// File: rtl/cam_pixel_packer.sv
// Camera pixel packer: gathers PIX_W pixels from a VSYNC/HREF camera bus into
// 32-bit little-endian words and pushes them into a downstream FIFO.
module cam_pixel_packer #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned LINE_CNT_W  = 12,
  parameter int unsigned FRAME_CNT_W = 16,
  parameter bit          FLUSH_EOL   = 1'b1,
  parameter logic [7:0]  PAD_VAL     = 8'h00
) (
  input  logic                   PCLKI,
  input  logic                   WBs_RST_i,
  input  logic                   VSYNCI,
  input  logic                   HREFI,
  input  logic [PIX_W-1:0]       CAM_DATA_i,
  input  logic                   CAP_EN_i,
  input  logic                   FIFO_FULL_i,
  input  logic                   OVF_CLR_i,
  output logic                   PUSH_o,
  output logic [31:0]            DIN_o,
  output logic                   SOF_o,
  output logic                   FRAME_DONE_o,
  output logic [LINE_CNT_W-1:0]  LINE_CNT_o,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT_o,
  output logic                   OVF_o,
  output logic                   BUSY_o
);

  localparam int unsigned      PPW      = 32 / PIX_W;
  localparam logic [1:0]       LAST_IDX = 2'(PPW - 1);
  localparam logic [PIX_W-1:0] PAD_PIX  = {(PIX_W / 8){PAD_VAL}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FRAME} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_vs_d, r_hr_d;
  logic [31:0]            r_acc;
  logic [1:0]             r_idx;
  logic [31:0]            r_din;
  logic                   r_push;
  logic                   r_sof_pend;
  logic                   r_frame_done;
  logic                   r_ovf;
  logic [LINE_CNT_W-1:0]  r_line_cnt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic        w_in_frame, w_pix_vld, w_vs_rise, w_vs_fall, w_hr_fall;
  logic        w_eol, w_eof, w_flush, w_entry, w_push_ok;
  logic [31:0] w_acc_nxt, w_flush_word;

  assign w_in_frame = (r_state == S_FRAME);
  assign w_pix_vld  = w_in_frame & HREFI & VSYNCI;
  assign w_vs_rise  = ~r_vs_d & VSYNCI;
  assign w_vs_fall  = r_vs_d & ~VSYNCI;
  assign w_hr_fall  = r_hr_d & ~HREFI;
  assign w_eol      = w_in_frame & w_hr_fall;
  assign w_eof      = w_in_frame & w_vs_fall;
  // A coincident line and frame end share the single flush below.
  assign w_flush    = FLUSH_EOL & (w_eol | w_eof) & (r_idx != 2'd0);
  assign w_entry    = (r_state == S_ARMED) & (w_state_nxt == S_FRAME);
  // FIFO full is judged on the push cycle itself; a dropped word is lost.
  assign w_push_ok  = r_push & ~FIFO_FULL_i;

  // Capture state register
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (CAP_EN_i) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (!CAP_EN_i)     w_state_nxt = S_IDLE;
        else if (w_vs_rise) w_state_nxt = S_FRAME;
      end
      S_FRAME: if (w_vs_fall) w_state_nxt = CAP_EN_i ? S_ARMED : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane insertion for the incoming pixel and padding for a partial flush
  always_comb begin
    w_acc_nxt    = r_acc;
    w_flush_word = r_acc;
    for (int k = 0; k < int'(PPW); k++) begin
      if (r_idx == 2'(k)) w_acc_nxt[k*PIX_W +: PIX_W] = CAM_DATA_i;
      if (2'(k) >= r_idx) w_flush_word[k*PIX_W +: PIX_W] = PAD_PIX;
    end
  end

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      r_vs_d       <= 1'b0;
      r_hr_d       <= 1'b0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_din        <= '0;
      r_push       <= 1'b0;
      r_sof_pend   <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
      r_line_cnt   <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_vs_d       <= VSYNCI;
      r_hr_d       <= HREFI;
      r_push       <= 1'b0;
      r_frame_done <= w_eof;

      if (w_entry) begin
        r_idx      <= '0;
        r_line_cnt <= '0;
      end else if (w_pix_vld) begin
        r_acc <= w_acc_nxt;
        if (r_idx == LAST_IDX) begin
          r_idx  <= '0;
          r_din  <= w_acc_nxt;
          r_push <= 1'b1;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end else if (w_eol || w_eof) begin
        r_idx <= '0;
        if (w_flush) begin
          r_din  <= w_flush_word;
          r_push <= 1'b1;
        end
      end

      if (w_eol && (r_line_cnt != '1)) r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
      if (w_eof) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);

      // SOF rides on the first word the FIFO actually accepts
      if (w_entry)        r_sof_pend <= 1'b1;
      else if (w_push_ok) r_sof_pend <= 1'b0;

      if (r_push && FIFO_FULL_i) r_ovf <= 1'b1;
      else if (OVF_CLR_i)        r_ovf <= 1'b0;
    end
  end

  assign PUSH_o       = w_push_ok;
  assign SOF_o        = w_push_ok & r_sof_pend;
  assign DIN_o        = r_din;
  assign FRAME_DONE_o = r_frame_done;
  assign LINE_CNT_o   = r_line_cnt;
  assign FRAME_CNT_o  = r_frame_cnt;
  assign OVF_o        = r_ovf;
  assign BUSY_o       = w_in_frame;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Scoreboard bench for cam_pixel_packer: default, no-flush/2-bit-frame-count
// and 16-bit-pixel instances driven from a shared camera bus.
module tb_cam_pixel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vsync, href, fifo_full, ovf_clr;
  logic        cap_a, cap_n, cap_w;
  logic [7:0]  data8;
  logic [15:0] data16;

  logic        push_a, sof_a, fd_a, ovf_a, busy_a;
  logic [31:0] din_a;
  logic [11:0] line_a;
  logic [15:0] fcnt_a;

  logic        push_n, sof_n, fd_n, ovf_n, busy_n;
  logic [31:0] din_n;
  logic [11:0] line_n;
  logic [1:0]  fcnt_n;

  logic        push_w, sof_w, fd_w, ovf_w, busy_w;
  logic [31:0] din_w;
  logic [11:0] line_w;
  logic [15:0] fcnt_w;

  cam_pixel_packer u_dut (
    .PCLKI(clk), .WBs_RST_i(rst), .VSYNCI(vsync), .HREFI(href), .CAM_DATA_i(data8),
    .CAP_EN_i(cap_a), .FIFO_FULL_i(fifo_full), .OVF_CLR_i(ovf_clr),
    .PUSH_o(push_a), .DIN_o(din_a), .SOF_o(sof_a), .FRAME_DONE_o(fd_a),
    .LINE_CNT_o(line_a), .FRAME_CNT_o(fcnt_a), .OVF_o(ovf_a), .BUSY_o(busy_a)
  );

  cam_pixel_packer #(.FLUSH_EOL(1'b0), .FRAME_CNT_W(2)) u_dut_nf (
    .PCLKI(clk), .WBs_RST_i(rst), .VSYNCI(vsync), .HREFI(href), .CAM_DATA_i(data8),
    .CAP_EN_i(cap_n), .FIFO_FULL_i(fifo_full), .OVF_CLR_i(ovf_clr),
    .PUSH_o(push_n), .DIN_o(din_n), .SOF_o(sof_n), .FRAME_DONE_o(fd_n),
    .LINE_CNT_o(line_n), .FRAME_CNT_o(fcnt_n), .OVF_o(ovf_n), .BUSY_o(busy_n)
  );

  cam_pixel_packer #(.PIX_W(16)) u_dut_w16 (
    .PCLKI(clk), .WBs_RST_i(rst), .VSYNCI(vsync), .HREFI(href), .CAM_DATA_i(data16),
    .CAP_EN_i(cap_w), .FIFO_FULL_i(fifo_full), .OVF_CLR_i(ovf_clr),
    .PUSH_o(push_w), .DIN_o(din_w), .SOF_o(sof_w), .FRAME_DONE_o(fd_w),
    .LINE_CNT_o(line_w), .FRAME_CNT_o(fcnt_w), .OVF_o(ovf_w), .BUSY_o(busy_w)
  );

  logic [32:0] q_a[$];
  logic [32:0] q_n[$];
  logic [32:0] q_w[$];
  bit          sof_a_m, sof_n_m;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: every push is popped against the scoreboard
  always @(negedge clk) begin
    if (push_a) begin
      if (q_a.size() == 0) check_eq("push_a_spurious", 64'(push_a), 64'(0));
      else check_eq("push_a", 64'({sof_a, din_a}), 64'(q_a.pop_front()));
    end
    if (push_n) begin
      if (q_n.size() == 0) check_eq("push_nf_spurious", 64'(push_n), 64'(0));
      else check_eq("push_nf", 64'({sof_n, din_n}), 64'(q_n.pop_front()));
    end
    if (push_w) begin
      if (q_w.size() == 0) check_eq("push_w16_spurious", 64'(push_w), 64'(0));
      else check_eq("push_w16", 64'({sof_w, din_w}), 64'(q_w.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int tgt, input logic [31:0] w);
    if (tgt == 0) begin
      q_a.push_back({sof_a_m, w});
      sof_a_m = 1'b0;
    end else if (tgt == 1) begin
      q_n.push_back({sof_n_m, w});
      sof_n_m = 1'b0;
    end
  endtask

  // tgt 0: default instance, 1: no-flush instance, other: nothing expected
  task automatic send_line(input int n, input logic [7:0] base, input int tgt);
    logic [31:0] w;
    int          k;
    w = '0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      href  = 1'b1;
      data8 = base + 8'(i);
      w[8*k +: 8] = base + 8'(i);
      k++;
      if (k == 4) begin
        push_exp(tgt, w);
        w = '0;
        k = 0;
      end
      tick();
    end
    href = 1'b0;
    tick();
    if (k != 0 && tgt == 0) begin
      push_exp(0, w);
      check_eq("eol_flush_latency", 64'(push_a), 64'(1));
    end
    tick();
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    href  = 1'b0;
    tick(2);
    sof_a_m = 1'b1;
    sof_n_m = 1'b1;
  endtask

  task automatic frame_end(input int tgt, input bit exp_fd);
    logic fd;
    vsync = 1'b0;
    href  = 1'b0;
    tick();
    fd = (tgt == 0) ? fd_a : (tgt == 1) ? fd_n : fd_w;
    check_eq("frame_done_pulse", 64'(fd), 64'(exp_fd));
    tick();
    fd = (tgt == 0) ? fd_a : (tgt == 1) ? fd_n : fd_w;
    check_eq("frame_done_clear", 64'(fd), 64'(0));
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;
    cap_a = 1'b0; cap_n = 1'b0; cap_w = 1'b0; data8 = '0; data16 = '0;
    tick(3);
    check_eq("rst_flags", 64'({push_a, sof_a, fd_a, ovf_a, busy_a}), 64'(0));
    check_eq("rst_din", 64'(din_a), 64'(0));
    check_eq("rst_counts", 64'({line_a, fcnt_a}), 64'(0));
    rst = 1'b0;
    tick();

    // Basic packing
    cap_a = 1'b1;
    tick();
    frame_start();
    check_eq("busy_in_frame", 64'(busy_a), 64'(1));
    send_line(8, 8'h01, 0);
    check_eq("line_cnt_basic", 64'(line_a), 64'(1));
    frame_end(0, 1'b1);
    check_eq("frame_cnt_1", 64'(fcnt_a), 64'(1));

    // End-of-line flush of 6 pixels
    frame_start();
    send_line(6, 8'h11, 0);
    check_eq("line_cnt_cleared", 64'(line_a), 64'(1));
    frame_end(0, 1'b1);

    // Overflow: first word dropped, SOF moves to the next accepted word
    frame_start();
    for (int i = 0; i < 8; i++) begin
      href      = 1'b1;
      data8     = 8'h01 + 8'(i);
      fifo_full = (i == 4);
      if (i == 7) begin
        sof_a_m = 1'b1;
        push_exp(0, 32'h08070605);
      end
      tick();
    end
    href = 1'b0; fifo_full = 1'b0;
    tick(2);
    check_eq("ovf_set", 64'(ovf_a), 64'(1));
    for (int i = 0; i < 4; i++) begin
      href  = 1'b1;
      data8 = 8'h21 + 8'(i);
      tick();
    end
    href = 1'b0; fifo_full = 1'b1; ovf_clr = 1'b1;
    tick();
    fifo_full = 1'b0; ovf_clr = 1'b0;
    check_eq("ovf_set_beats_clr", 64'(ovf_a), 64'(1));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 64'(ovf_a), 64'(0));
    frame_end(0, 1'b1);
    check_eq("frame_cnt_3", 64'(fcnt_a), 64'(3));

    // Reset after two pixels of a word
    frame_start();
    href = 1'b1; data8 = 8'h61;
    tick();
    data8 = 8'h62;
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst_mid_flags", 64'({push_a, sof_a, fd_a, ovf_a, busy_a}), 64'(0));
    check_eq("rst_mid_din", 64'(din_a), 64'(0));
    check_eq("rst_mid_counts", 64'({line_a, fcnt_a}), 64'(0));
    href = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    check_eq("no_capture_after_rst", 64'(busy_a), 64'(0));
    vsync = 1'b0;
    tick(2);

    // Three frames of two lines
    for (int f = 0; f < 3; f++) begin
      frame_start();
      send_line(4, 8'h71 + 8'(f * 8), 0);
      send_line(4, 8'h75 + 8'(f * 8), 0);
      frame_end(0, 1'b1);
    end
    check_eq("frame_cnt_three", 64'(fcnt_a), 64'(3));
    check_eq("line_cnt_held", 64'(line_a), 64'(2));

    // Arming while a frame is already in progress
    cap_a = 1'b0;
    tick(2);
    vsync = 1'b1;
    tick(2);
    cap_a = 1'b1;
    tick(2);
    send_line(4, 8'h81, 2);
    check_eq("skip_frame_busy", 64'(busy_a), 64'(0));
    frame_end(0, 1'b0);

    // Capture disabled mid-frame: the frame still completes
    frame_start();
    send_line(4, 8'h91, 0);
    cap_a = 1'b0;
    send_line(4, 8'h95, 0);
    check_eq("busy_after_disable", 64'(busy_a), 64'(1));
    frame_end(0, 1'b1);
    check_eq("busy_idle", 64'(busy_a), 64'(0));
    frame_start();
    check_eq("no_rearm", 64'(busy_a), 64'(0));
    send_line(4, 8'hA1, 2);
    frame_end(0, 1'b0);
    check_eq("frame_cnt_4", 64'(fcnt_a), 64'(4));

    // No-flush instance and 2-bit frame counter wrap
    cap_n = 1'b1;
    tick();
    frame_start();
    send_line(6, 8'h11, 1);
    frame_end(1, 1'b1);
    for (int f = 0; f < 4; f++) begin
      frame_start();
      frame_end(1, 1'b1);
    end
    check_eq("frame_cnt_wrap", 64'(fcnt_n), 64'(1));
    cap_n = 1'b0;

    // 16-bit pixels
    cap_w = 1'b1;
    tick();
    frame_start();
    q_w.push_back({1'b1, 32'hBBBBAAAA});
    href = 1'b1; data16 = 16'hAAAA;
    tick();
    data16 = 16'hBBBB;
    tick();
    href = 1'b0;
    tick(2);
    q_w.push_back({1'b0, 32'h22221111});
    q_w.push_back({1'b0, 32'h00003333});
    href = 1'b1; data16 = 16'h1111;
    tick();
    data16 = 16'h2222;
    tick();
    data16 = 16'h3333;
    tick();
    href = 1'b0;
    tick(2);
    check_eq("w16_line_cnt", 64'(line_w), 64'(2));
    frame_end(2, 1'b1);
    cap_w = 1'b0;

    tick(4);
    check_eq("q_a_drained", 64'(q_a.size()), 64'(0));
    check_eq("q_nf_drained", 64'(q_n.size()), 64'(0));
    check_eq("q_w16_drained", 64'(q_w.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
